dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the single-port 64-word data memory.
- Shares the memory between the CPU load/store unit (m0) and a second master (m1: program loader / debug port).
- Serialises accesses through a 3-state FSM with round-robin fairness.
- Returns registered read data and a one-cycle ack to the granted master.

Parameters:
- ADDR_W, 32, address width of masters and memory port.
- DATA_W, 32, data width.
- MEM_WORDS, 64, memory depth in words; used only by the optional address check.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 access request; held until m0_ack.
- m0_we  in  1  master 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ack  out  1  master 0 completion pulse.
- m0_rdata  out  DATA_W  master 0 read data, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0 for master 1.
- mem_write  out  1  to memory write enable.
- mem_read  out  1  to memory read enable.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  DATA_W  to memory write data.
- mem_read_data  in  DATA_W  from memory, combinational read.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, last_grant = 1 (m0 wins the first tie).
  - Latched addr/wdata/we/owner = 0.
  - m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0.
  - mem_* outputs = 0.
- FSM states: IDLE, SERVE, RESP.
- IDLE:
  - No req: stay.
  - Any req: choose owner, latch that master's we/addr/wdata, go to SERVE.
  - Only one req: that master is the owner.
  - Both req: owner = !last_grant.
- SERVE (exactly 1 cycle):
  - mem_address = latched addr, mem_write_data = latched wdata.
  - mem_write = latched we, mem_read = !latched we.
  - On read: capture mem_read_data into the owner's rdata register at the clock edge. On write: owner's rdata is unchanged.
  - Go to RESP.
- RESP (1 cycle): owner's ack = 1; last_grant <= owner; go to IDLE.
- mem_* outputs are decoded from state and the latched registers.
  - In IDLE and RESP: mem_write = mem_read = 0 and mem_address = mem_write_data = 0.
- ack and rdata are registers; rdata holds its value until the next read completes for that master.
- Latency: req sampled at edge e0, memory accessed during cycle e0–e1, ack high during e1–e2.
  - Throughput is at most one access per 3 cycles.
- Handshake:
  - Master keeps req/we/addr/wdata stable until it samples ack = 1.
  - Master must update req before the next IDLE sampling edge; req still high there is a new request.
  - Master signals change after grant are ignored, because the access uses the latched copy.
- Fairness: with both req held continuously, grants alternate m0, m1, m0, ...; no master waits more than one foreign access.
- Simultaneous events: a new req from the non-owner during SERVE/RESP is not lost; it is sampled in the next IDLE.
- Reset mid-operation: the FSM returns to IDLE asynchronously and mem_write drops immediately. An access interrupted in SERVE performs no write and produces no ack.
- Address passes through unmodified; the memory decodes word index from address[7:2].

Optional Feature:
- Macro: DMEM_ADDR_CHECK_EN.
- Defined:
  - Adds outputs m0_err and m1_err (1 bit each, reset 0).
  - In SERVE, a latched addr with addr[1:0] != 0 or addr >= MEM_WORDS*4 suppresses the access: mem_write = mem_read = 0.
  - Owner's rdata <= 0.
  - In RESP, the owner's err pulses together with its ack.
- Undefined: no err ports; every address is forwarded and aliases modulo 256 bytes.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, SERVE, RESP}.
  - Owner encoding constants OWN_M0 = 0, OWN_M1 = 1.
  - Defaults for ADDR_W, DATA_W and MEM_WORDS.
- Sub-module rr_arb2: combinational 2-way round-robin pick.
  - Inputs: req0, req1, last_grant.
  - Outputs: gnt_valid, gnt_id.

Test Plan:
- Pre-load mem word 3 = 0xDEADBEEF; m0 read addr 0x0C → mem_read = 1 in cycle 1, m0_ack in cycle 2 with m0_rdata = 0xDEADBEEF, m1_ack stays 0.
- m1 write 0x12345678 to addr 0x20, then m0 read 0x20 → exactly one mem_write pulse; m0_rdata = 0x12345678; m1_rdata unchanged (0).
- m0 and m1 raise req in the same cycle just after reset → m0 served first (ack at cycle 2), m1 ack at cycle 5.
- Both reqs held for 12 cycles → 4 acks alternating m0, m1, m0, m1; mem_write/mem_read never high in IDLE or RESP.
- Assert rst_n = 0 while in SERVE of an m1 write to 0x10 → mem_write falls immediately, no ack, mem word 4 unchanged, FSM in IDLE after release.
- With DMEM_ADDR_CHECK_EN: m0 read 0x102 → no mem_read pulse, m0_ack and m0_err pulse together, m0_rdata = 0. Without the macro: the same read returns word 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional build macro DMEM_ADDR_CHECK_EN is consumed by the interface and top.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_WORDS_DEF = 64;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the single-port memory.
// With DMEM_ADDR_CHECK_EN defined the bundle also carries m0_err / m1_err.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

`ifdef DMEM_ADDR_CHECK_EN
  logic              m0_err;
  logic              m1_err;
`endif

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_write, mem_read, mem_address, mem_write_data,
`ifdef DMEM_ADDR_CHECK_EN
    output m0_err, m1_err,
`endif
    input  mem_read_data
  );

  // Requester/memory side.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_write, mem_read, mem_address, mem_write_data,
`ifdef DMEM_ADDR_CHECK_EN
    input  m0_err, m1_err,
`endif
    output mem_read_data
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the master that did not
// win last time gets the grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = OWN_M0;
    if (req0 && req1) begin
      gnt_id = ~last_grant;
    end else if (req1) begin
      gnt_id = OWN_M1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter and access sequencer for the 64-word data memory.
// Build macro DMEM_ADDR_CHECK_EN adds alignment/range checking with err pulses.
//
// state | meaning
// IDLE  | wait for a request; pick owner and latch its we/addr/wdata
// SERVE | drive memory from the latched copy; capture read data
// RESP  | owner's ack (and err) high; remember owner for fairness
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef DMEM_ADDR_CHECK_EN
  , parameter int MEM_WORDS = MEM_WORDS_DEF
`endif
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              own_q, own_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
`ifdef DMEM_ADDR_CHECK_EN
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
`endif

  logic              gnt_valid;
  logic              gnt_id;
  logic              access_ok;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;

  rr_arb2 u_rr_arb2 (
    .req0      (bus.m0_req),
    .req1      (bus.m1_req),
    .last_grant(last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

`ifdef DMEM_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * 4);
  assign access_ok = (addr_q[1:0] == 2'b00) && (addr_q < ADDR_LIMIT);
`else
  // Unchecked build: every address is forwarded and aliases in the memory.
  assign access_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    own_d    = own_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef DMEM_ADDR_CHECK_EN
    err0_d   = 1'b0;
    err1_d   = 1'b0;
`endif
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          own_d   = gnt_id;
          state_d = SERVE;
          if (gnt_id == OWN_M1) begin
            we_d    = bus.m1_we;
            addr_d  = bus.m1_addr;
            wdata_d = bus.m1_wdata;
          end else begin
            we_d    = bus.m0_we;
            addr_d  = bus.m0_addr;
            wdata_d = bus.m0_wdata;
          end
        end
      end

      SERVE: begin
        mem_addr = addr_q;
        mem_wd   = wdata_q;
        mem_we   = we_q & access_ok;
        mem_re   = ~we_q & access_ok;
        // ack is registered here so it is visible for exactly the RESP cycle
        if (own_q == OWN_M1) begin
          ack1_d = 1'b1;
          if (!access_ok)  rdata1_d = '0;
          else if (!we_q)  rdata1_d = bus.mem_read_data;
`ifdef DMEM_ADDR_CHECK_EN
          err1_d = ~access_ok;
`endif
        end else begin
          ack0_d = 1'b1;
          if (!access_ok)  rdata0_d = '0;
          else if (!we_q)  rdata0_d = bus.mem_read_data;
`ifdef DMEM_ADDR_CHECK_EN
          err0_d = ~access_ok;
`endif
        end
        state_d = RESP;
      end

      RESP: begin
        last_d  = own_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= OWN_M1;
      own_q    <= OWN_M0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ADDR_CHECK_EN
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      own_q    <= own_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DMEM_ADDR_CHECK_EN
      err0_q   <= err0_d;
      err1_q   <= err1_d;
`endif
    end
  end

  assign bus.m0_ack         = ack0_q;
  assign bus.m1_ack         = ack1_q;
  assign bus.m0_rdata       = rdata0_q;
  assign bus.m1_rdata       = rdata1_q;
  assign bus.mem_write      = mem_we;
  assign bus.mem_read       = mem_re;
  assign bus.mem_address    = mem_addr;
  assign bus.mem_write_data = mem_wd;
`ifdef DMEM_ADDR_CHECK_EN
  assign bus.m0_err         = err0_q;
  assign bus.m1_err         = err1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: cycle-stamp transaction model plus
// directed scenarios; follows DMEM_ADDR_CHECK_EN when defined.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic do_preload = 1'b1;
  int   cnt = 0;
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 3) return 32'hDEAD_BEEF;
    if (i == 0) return 32'hA5A5_0000;
    return 32'h1000_0000 + 32'(i);
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'd256);
`else
    return (a[1:0] != a[1:0]);
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory behind the arbiter: combinational read, clocked write.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bus.mem_write) begin
      mem[bus.mem_address[7:2]] <= bus.mem_write_data;
    end
  end
  assign bus.mem_read_data = mem[bus.mem_address[7:2]];

  always @(posedge clk) cnt <= cnt + 1;

  // Transaction model: a request seen at sampling edge g occupies the memory
  // in the cycle after edge g, acks in the cycle after edge g+1, and the
  // arbiter can sample again at edge g+3.
  logic [DW-1:0] ref_mem [64];
  int            g_edge  = -100;
  int            free_at = 0;
  logic          m_last, m_own, m_we;
  logic [31:0]   m_addr, m_wdata;
  logic [31:0]   exp_rd0, exp_rd1;

  always @(posedge clk or negedge rst_n) begin
    int   e;
    logic pick;
    if (!rst_n) begin
      if (do_preload) for (int i = 0; i < 64; i++) ref_mem[i] <= init_word(i);
      g_edge  <= -100;
      free_at <= 0;
      m_last  <= 1'b1;
      m_own   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      exp_rd0 <= '0;
      exp_rd1 <= '0;
    end else begin
      e = cnt + 1;
      if (e == g_edge + 1) begin
        if (bad_addr(m_addr)) begin
          if (m_own) exp_rd1 <= '0; else exp_rd0 <= '0;
        end else if (m_we) begin
          ref_mem[m_addr[7:2]] <= m_wdata;
        end else begin
          if (m_own) exp_rd1 <= ref_mem[m_addr[7:2]]; else exp_rd0 <= ref_mem[m_addr[7:2]];
        end
      end
      if (e >= free_at && (bus.m0_req || bus.m1_req)) begin
        pick    = (bus.m0_req && bus.m1_req) ? !m_last : bus.m1_req;
        m_own   <= pick;
        m_last  <= pick;
        m_we    <= pick ? bus.m1_we    : bus.m0_we;
        m_addr  <= pick ? bus.m1_addr  : bus.m0_addr;
        m_wdata <= pick ? bus.m1_wdata : bus.m0_wdata;
        g_edge  <= e;
        free_at <= e + 3;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic acc, ackc, bad;
    if (rst_n && !do_preload) begin
      acc  = (cnt == g_edge);
      ackc = (cnt == g_edge + 1);
      bad  = bad_addr(m_addr);
      chk("mem_write",      bus.mem_write,      acc && m_we && !bad);
      chk("mem_read",       bus.mem_read,       acc && !m_we && !bad);
      chk("mem_address",    bus.mem_address,    acc ? m_addr  : 32'h0);
      chk("mem_write_data", bus.mem_write_data, acc ? m_wdata : 32'h0);
      chk("m0_ack",         bus.m0_ack,         ackc && !m_own);
      chk("m1_ack",         bus.m1_ack,         ackc && m_own);
      chk("m0_rdata",       bus.m0_rdata,       exp_rd0);
      chk("m1_rdata",       bus.m1_rdata,       exp_rd1);
`ifdef DMEM_ADDR_CHECK_EN
      chk("m0_err",         bus.m0_err,         ackc && !m_own && bad);
      chk("m1_err",         bus.m1_err,         ackc && m_own && bad);
`endif
    end
  end

  // Event bookkeeping for the directed checks.
  int n_rd = 0, n_wr = 0, n_ack0 = 0, n_ack1 = 0, last_rd_cnt = -1, n_err0 = 0;
  int ack_order [$];
  always @(negedge clk) begin
    if (bus.mem_read)  begin n_rd++; last_rd_cnt = cnt; end
    if (bus.mem_write) n_wr++;
    if (bus.m0_ack)    begin n_ack0++; ack_order.push_back(0); end
    if (bus.m1_ack)    begin n_ack1++; ack_order.push_back(1); end
`ifdef DMEM_ADDR_CHECK_EN
    if (bus.m0_ack && bus.m0_err) n_err0++;
`endif
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic xfer(input int m, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, output int start, output int ack_at);
    if (m == 0) begin
      bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_req = 1'b1;
    end else begin
      bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_req = 1'b1;
    end
    start  = cnt;
    ack_at = -1;
    for (int i = 0; i < 20 && ack_at < 0; i++) begin
      @(negedge clk);
      if ((m == 0 && bus.m0_ack) || (m == 1 && bus.m1_ack)) ack_at = cnt - start;
    end
    if (ack_at < 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL ack_timeout: master %0d got no ack within 20 cycles", m);
    end
    @(posedge clk);
    #1;
    if (m == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0, a0, s1, a1, wr0, rd0, ack1_0, found;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    @(posedge clk);
    #1 do_preload = 1'b0;
    do_reset();

    // Reset state
    chk("rst_m0_ack",    bus.m0_ack,    0);
    chk("rst_m1_ack",    bus.m1_ack,    0);
    chk("rst_m0_rdata",  bus.m0_rdata,  0);
    chk("rst_mem_read",  bus.mem_read,  0);
    chk("rst_mem_write", bus.mem_write, 0);

    // m0 read of word 3
    ack1_0 = n_ack1;
    xfer(0, 1'b0, 32'h0C, 32'h0, s0, a0);
    chk("t1_ack_cycle",  a0, 2);
    chk("t1_read_cycle", last_rd_cnt - s0, 1);
    chk("t1_rdata",      bus.m0_rdata, 32'hDEAD_BEEF);
    chk("t1_no_m1_ack",  n_ack1 - ack1_0, 0);

    // m1 write then m0 read-back
    wr0 = n_wr;
    xfer(1, 1'b1, 32'h20, 32'h1234_5678, s1, a1);
    xfer(0, 1'b0, 32'h20, 32'h0, s0, a0);
    chk("t2_one_write",  n_wr - wr0, 1);
    chk("t2_m0_rdata",   bus.m0_rdata, 32'h1234_5678);
    chk("t2_m1_rdata",   bus.m1_rdata, 32'h0);
    chk("t2_mem_word8",  mem[8], 32'h1234_5678);

    // Simultaneous requests right after reset
    do_reset();
    fork
      xfer(0, 1'b0, 32'h0C, 32'h0, s0, a0);
      xfer(1, 1'b0, 32'h04, 32'h0, s1, a1);
    join
    chk("t3_m0_ack_cycle", a0, 2);
    chk("t3_m1_ack_cycle", a1, 5);
    chk("t3_m1_rdata",     bus.m1_rdata, 32'h1000_0001);

    // Both requests held for 12 cycles
    do_reset();
    ack_order.delete();
    bus.m0_we = 0; bus.m0_addr = 32'h00; bus.m0_req = 1;
    bus.m1_we = 0; bus.m1_addr = 32'h08; bus.m1_req = 1;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1 bus.m0_req = 0; bus.m1_req = 0;
    chk("t4_ack_count", ack_order.size(), 4);
    if (ack_order.size() == 4) begin
      chk("t4_order0", ack_order[0], 0);
      chk("t4_order1", ack_order[1], 1);
      chk("t4_order2", ack_order[2], 0);
      chk("t4_order3", ack_order[3], 1);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset during SERVE of an m1 write
    ack1_0 = n_ack1;
    bus.m1_we = 1; bus.m1_addr = 32'h10; bus.m1_wdata = 32'hCAFE_F00D; bus.m1_req = 1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (bus.mem_write) found = 1;
    end
    chk("t5_serve_reached", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_write_drops", bus.mem_write, 0);
    chk("t5_addr_drops",  bus.mem_address, 0);
    bus.m1_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_ack",    n_ack1 - ack1_0, 0);
    chk("t5_mem_word4", mem[4], 32'h1000_0004);
    xfer(0, 1'b0, 32'h10, 32'h0, s0, a0);
    chk("t5_idle_after", a0, 2);
    chk("t5_rdata",      bus.m0_rdata, 32'h1000_0004);

    // Out-of-range / misaligned address 0x102
    rd0 = n_rd;
    xfer(0, 1'b0, 32'h102, 32'h0, s0, a0);
    chk("t6_ack_cycle", a0, 2);
`ifdef DMEM_ADDR_CHECK_EN
    chk("t6_no_read",  n_rd - rd0, 0);
    chk("t6_err_pulse", n_err0, 1);
    chk("t6_rdata",    bus.m0_rdata, 32'h0);
`else
    chk("t6_one_read", n_rd - rd0, 1);
    chk("t6_rdata",    bus.m0_rdata, 32'hA5A5_0000);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
